// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory arbiter slice: default widths,
//   FSM state encoding (ARB / CLEAR) and the grant encoding used by the
//   output mux.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_ADDR_W = 15;
  localparam int DMEM_DATA_W = 16;

  // FSM state encoding, kept as plain constants so older tools can use it.
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_e;

endpackage

// File: rtl/dmem_clear_seq.sv
// -----------------------------------------------------------------------------
// dmem_clear_seq
//   Zero-fill sequencer. On i_start (only while in ARB) it enters CLEAR and
//   writes one word per cycle to addresses 0..CLR_WORDS-1, then returns to
//   ARB and raises o_done for one cycle. A start seen during CLEAR is ignored.
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          start pulse
//   o_busy           CLEAR state active
//   o_done           one-cycle pulse after the final clear write
//   o_wr_en          clear write enable toward the arbiter mux
//   o_wr_addr        clear write address toward the arbiter mux
// -----------------------------------------------------------------------------
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int CLR_WORDS = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr
);

  localparam int CNT_W = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(CLR_WORDS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ARB;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_ARB: begin
          if (i_start) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        default: begin
          // The write to r_cnt happens this cycle; the last word ends CLEAR.
          if (w_last) begin
            r_state <= ST_ARB;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_busy    = (r_state == ST_CLEAR);
  assign o_wr_en   = (r_state == ST_CLEAR);
  assign o_wr_addr = ADDR_W'(r_cnt);
  assign o_done    = r_done;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory between port A (CPU, priority) and
//   port B (loader/debug). A wins unless B has waited through MAX_STREAK
//   consecutive A grants. A zero-fill sequencer can take the memory over.
// Ports
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_a_* / o_a_*                     port A request, ready, read response
//   i_b_* / o_b_*                     port B request, ready, read response
//   i_clr_start, o_clr_busy/done      zero-fill control and status
//   o_mem_load/address/in, i_mem_out  memory interface (1-cycle read latency)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int MAX_STREAK = 4,
  parameter int CLR_WORDS  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  output logic              o_a_ready,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_rsp_valid,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_valid,
  output logic              o_b_ready,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_rsp_valid,
  output logic [DATA_W-1:0] o_b_rdata,
  input  logic              i_clr_start,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_mem_load,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_in,
  input  logic [DATA_W-1:0] i_mem_out
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(MAX_STREAK)) ? v : v + 1'b1;
  endfunction

  logic              w_clr_busy;
  logic              w_clr_done;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;

  gnt_e              w_gnt;
  logic              w_load;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic [SW-1:0]     r_streak;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;
  logic              r_a_rsp_vld;
  logic              r_b_rsp_vld;

  dmem_clear_seq #(
    .ADDR_W   (ADDR_W),
    .CLR_WORDS(CLR_WORDS)
  ) u_clr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_clr_start),
    .o_busy   (w_clr_busy),
    .o_done   (w_clr_done),
    .o_wr_en  (w_clr_en),
    .o_wr_addr(w_clr_addr)
  );

  // Grant is gated by rst_n so ready and mem_load drop as soon as reset asserts.
  always_comb begin
    w_gnt = GNT_NONE;
    if (i_rst_n && !w_clr_busy) begin
      if (i_a_valid && (!i_b_valid || (r_streak < SW'(MAX_STREAK))))
        w_gnt = GNT_A;
      else if (i_b_valid)
        w_gnt = GNT_B;
    end
  end

  assign o_a_ready = (w_gnt == GNT_A);
  assign o_b_ready = (w_gnt == GNT_B);

  // Idle cycles replay the last driven address/data so the bus stays quiet.
  always_comb begin
    w_load  = 1'b0;
    w_addr  = r_last_addr;
    w_wdata = r_last_wdata;
    case (w_gnt)
      GNT_A: begin
        w_load  = i_a_we;
        w_addr  = i_a_addr;
        w_wdata = i_a_wdata;
      end
      GNT_B: begin
        w_load  = i_b_we;
        w_addr  = i_b_addr;
        w_wdata = i_b_wdata;
      end
      default: begin
        if (w_clr_en) begin
          w_load  = 1'b1;
          w_addr  = w_clr_addr;
          w_wdata = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak     <= '0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_a_rsp_vld  <= 1'b0;
      r_b_rsp_vld  <= 1'b0;
    end else begin
      // The streak only counts A wins that made B wait.
      if (!i_b_valid || (w_gnt == GNT_B))
        r_streak <= '0;
      else if (w_gnt == GNT_A)
        r_streak <= sat_inc(r_streak);

      if ((w_gnt != GNT_NONE) || w_clr_en) begin
        r_last_addr  <= w_addr;
        r_last_wdata <= w_wdata;
      end

      // Memory output is registered, so a read returns exactly one cycle later.
      r_a_rsp_vld <= (w_gnt == GNT_A) && !i_a_we;
      r_b_rsp_vld <= (w_gnt == GNT_B) && !i_b_we;
    end
  end

  assign o_mem_load    = w_load;
  assign o_mem_address = w_addr;
  assign o_mem_in      = w_wdata;

  assign o_a_rsp_valid = r_a_rsp_vld;
  assign o_b_rsp_valid = r_b_rsp_vld;
  assign o_a_rdata     = r_a_rsp_vld ? i_mem_out : '0;
  assign o_b_rdata     = r_b_rsp_vld ? i_mem_out : '0;

  assign o_clr_busy = w_clr_busy;
  assign o_clr_done = w_clr_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Bench for dmem_arbiter with a behavioural 16K x 16 memory attached.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_we, b_valid, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [15:0] a_rdata, b_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic        mem_load;
  logic [14:0] mem_address;
  logic [15:0] mem_in, mem_out;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(15), .DATA_W(16), .MAX_STREAK(4), .CLR_WORDS(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_we(a_we),
    .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_rsp_valid(a_rsp_valid), .o_a_rdata(a_rdata),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_we(b_we),
    .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_rsp_valid(b_rsp_valid), .o_b_rdata(b_rdata),
    .i_clr_start(clr_start), .o_clr_busy(clr_busy), .o_clr_done(clr_done),
    .o_mem_load(mem_load), .o_mem_address(mem_address), .o_mem_in(mem_in),
    .i_mem_out(mem_out)
  );

  // Memory model: low 14 address bits decoded, registered read.
  logic [15:0] mem [0:16383];

  function automatic int midx(input logic [14:0] a);
    return int'(a) & 16'h3FFF;
  endfunction

  always @(posedge clk) begin
    if (mem_load) mem[midx(mem_address)] <= mem_in;
    mem_out <= mem[midx(mem_address)];
  end

  // Scoreboard state
  typedef struct { int cyc; logic [15:0] data; } rsp_t;
  rsp_t        qa[$];
  rsp_t        qb[$];
  logic [15:0] shadow [0:16383];
  logic [14:0] last_addr;
  logic        g_clr, g_done;
  int          g_cnt;
  int          cyc;
  int          checks, failures;

  typedef struct {
    logic av, awe; logic [14:0] aa; logic [15:0] ad;
    logic bv, bwe; logic [14:0] ba; logic [15:0] bd;
    logic ear, ebr;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic vld, input logic [15:0] dat,
                         inout rsp_t q[$]);
    logic exp_v;
    exp_v = 1'b0;
    if (q.size() > 0) exp_v = (q[0].cyc == cyc - 1);
    chk({name, "_rsp_valid"}, vld, exp_v);
    if (exp_v) begin
      chk({name, "_rdata"}, dat, q[0].data);
      void'(q.pop_front());
    end
  endtask

  task automatic step(input logic av, input logic awe, input logic [14:0] aa,
                      input logic [15:0] ad, input logic bv, input logic bwe,
                      input logic [14:0] ba, input logic [15:0] bd,
                      input logic ear, input logic ebr);
    logic        exp_ld;
    logic [14:0] exp_addr;
    logic [15:0] exp_in;
    rsp_t        r;
    a_valid = av; a_we = awe; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bwe; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    chk_rsp("a", a_rsp_valid, a_rdata, qa);
    chk_rsp("b", b_rsp_valid, b_rdata, qb);
    chk("a_ready", a_ready, ear);
    chk("b_ready", b_ready, ebr);
    exp_ld   = (ear & awe) | (ebr & bwe) | g_clr;
    exp_addr = ear ? aa : ebr ? ba : g_clr ? 15'(g_cnt) : last_addr;
    exp_in   = ear ? ad : ebr ? bd : 16'h0000;
    chk("mem_load", mem_load, exp_ld);
    chk("mem_address", mem_address, exp_addr);
    if (exp_ld) chk("mem_in", mem_in, exp_in);
    chk("clr_busy", clr_busy, g_clr);
    chk("clr_done", clr_done, g_done);
    if (ear | ebr | g_clr) last_addr = exp_addr;
    if (ear) begin
      if (awe) shadow[midx(aa)] = ad;
      else begin r.cyc = cyc; r.data = shadow[midx(aa)]; qa.push_back(r); end
    end
    if (ebr) begin
      if (bwe) shadow[midx(ba)] = bd;
      else begin r.cyc = cyc; r.data = shadow[midx(ba)]; qb.push_back(r); end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0, 0, 0);
  endtask

  task automatic a_op(input logic we, input logic [14:0] ad, input logic [15:0] d);
    step(1, we, ad, d, 0, 0, 15'h0, 16'h0, 1, 0);
  endtask

  task automatic chk_all_zero();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_mem_load", mem_load, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_a_rsp", {a_rsp_valid, a_rdata}, 0);
    chk("rst_b_rsp", {b_rsp_valid, b_rdata}, 0);
    chk("rst_clr", {clr_busy, clr_done}, 0);
  endtask

  task automatic after_reset();
    qa.delete(); qb.delete();
    last_addr = '0; g_clr = 0; g_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    g_clr = 0; g_done = 0; g_cnt = 0; last_addr = '0;
    rst_n = 1'b0; clr_start = 1'b0;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    // Reset state
    #2;
    chk_all_zero();
    after_reset();

    // Directed table: single-port traffic, aliasing, mixed A/B priority
    tbl[0]  = '{1, 1, 15'd5,     16'h1234, 0, 0, 15'd0, 16'h0,    1, 0};
    tbl[1]  = '{1, 0, 15'd5,     16'h0,    0, 0, 15'd0, 16'h0,    1, 0};
    tbl[2]  = '{0, 0, 15'd0,     16'h0,    0, 0, 15'd0, 16'h0,    0, 0};
    tbl[3]  = '{0, 0, 15'd0,     16'h0,    1, 1, 15'd2, 16'h0003, 0, 1};
    tbl[4]  = '{0, 0, 15'd0,     16'h0,    1, 0, 15'd2, 16'h0,    0, 1};
    tbl[5]  = '{0, 0, 15'd0,     16'h0,    0, 0, 15'd0, 16'h0,    0, 0};
    tbl[6]  = '{1, 1, 15'd16393, 16'hBEEF, 0, 0, 15'd0, 16'h0,    1, 0};
    tbl[7]  = '{1, 0, 15'd9,     16'h0,    0, 0, 15'd0, 16'h0,    1, 0};
    tbl[8]  = '{1, 0, 15'd5,     16'h0,    1, 0, 15'd2, 16'h0,    1, 0};
    tbl[9]  = '{0, 0, 15'd0,     16'h0,    1, 0, 15'd2, 16'h0,    0, 1};
    tbl[10] = '{1, 1, 15'd7,     16'h00A5, 1, 1, 15'd8, 16'h5A00, 1, 0};
    tbl[11] = '{0, 0, 15'd0,     16'h0,    1, 1, 15'd8, 16'h5A00, 0, 1};
    tbl[12] = '{1, 0, 15'd7,     16'h0,    1, 0, 15'd8, 16'h0,    1, 0};
    tbl[13] = '{0, 0, 15'd0,     16'h0,    1, 0, 15'd8, 16'h0,    0, 1};
    tbl[14] = '{0, 0, 15'd0,     16'h0,    0, 0, 15'd0, 16'h0,    0, 0};
    for (int i = 0; i < 15; i++)
      step(tbl[i].av, tbl[i].awe, tbl[i].aa, tbl[i].ad,
           tbl[i].bv, tbl[i].bwe, tbl[i].ba, tbl[i].bd, tbl[i].ear, tbl[i].ebr);

    // Both ports continuously valid: AAAAB repeating
    for (int i = 0; i < 10; i++)
      step(1, 0, 15'd5, 16'h0, 1, 0, 15'd2, 16'h0, (i % 5) != 4, (i % 5) == 4);

    // Reset mid-traffic with a non-zero streak and a response in flight
    step(1, 0, 15'd7, 16'h0, 1, 0, 15'd8, 16'h0, 1, 0);
    step(1, 0, 15'd5, 16'h0, 1, 0, 15'd8, 16'h0, 1, 0);
    a_valid = 1; a_we = 1; a_addr = 15'd5; a_wdata = 16'hDEAD; b_valid = 1;
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    after_reset();
    for (int i = 0; i < 5; i++)
      step(1, 0, 15'd7, 16'h0, 1, 0, 15'd2, 16'h0, i != 4, i == 4);
    idle();

    // Full clear: preload, start with a read in flight, retrigger ignored
    for (int i = 0; i <= 16; i++) a_op(1, 15'(i), 16'hFFFF);
    clr_start = 1'b1;
    a_op(0, 15'd16, 16'h0);
    clr_start = 1'b0;
    g_clr = 1;
    for (int k = 0; k < 16; k++) begin
      g_cnt = k;
      clr_start = (k == 5);
      step(1, 0, 15'd3, 16'h0, 1, 0, 15'd4, 16'h0, 0, 0);
      shadow[k] = 16'h0000;
    end
    clr_start = 1'b0;
    g_clr = 0; g_done = 1;
    idle();
    g_done = 0;
    idle();
    for (int i = 0; i <= 16; i++) a_op(0, 15'(i), 16'h0);
    idle();

    // Reset while clearing word 7
    for (int i = 0; i < 16; i++) a_op(1, 15'(i), 16'hFFFF);
    clr_start = 1'b1;
    idle();
    clr_start = 1'b0;
    g_clr = 1;
    for (int k = 0; k < 7; k++) begin
      g_cnt = k;
      idle();
      shadow[k] = 16'h0000;
    end
    a_valid = 0; b_valid = 0;
    #1;
    chk("clr7_mem_address", mem_address, 15'd7);
    chk("clr7_busy", clr_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("clr7_rst_busy", clr_busy, 0);
    chk("clr7_rst_load", mem_load, 0);
    after_reset();
    for (int i = 0; i < 3; i++) idle();
    for (int i = 0; i <= 8; i++) a_op(0, 15'(i), 16'h0);
    step(1, 0, 15'd3, 16'h0, 1, 0, 15'd9, 16'h0, 1, 0);
    step(0, 0, 15'd0, 16'h0, 1, 0, 15'd9, 16'h0, 0, 1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
